// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg: shared sequencer-state, load-size and FSM encodings for the writeback unit
package writeback_unit_pkg;
    localparam logic [5:0] ST_FETCH  = 6'b000001;
    localparam logic [5:0] ST_DECODE = 6'b000010;
    localparam logic [5:0] ST_EXEC   = 6'b000100;
    localparam logic [5:0] ST_MEM    = 6'b001000;
    localparam logic [5:0] ST_WB     = 6'b010000;
    localparam logic [1:0] LS_WORD = 2'b00;
    localparam logic [1:0] LS_HALF = 2'b01;
    localparam logic [1:0] LS_BYTE = 2'b10;
    localparam logic [4:0] REG_ZERO = 5'd0;
    typedef enum logic [2:0] {IDLE, ARMED, WAIT_MEM, READY, WRITE, DONE} wb_state_t;
    // reserved size 11 behaves as a word, so it needs full word alignment
    function automatic logic misaligned(input logic [1:0] ls, input logic [1:0] addr);
        return ls == LS_BYTE ? 1'b0 : ls == LS_HALF ? addr[0] : addr != 2'b00;
    endfunction
endpackage

// File: rtl/writeback_unit_if.sv
// writeback_unit_if: data-memory read return plus register-file write port and status pulses
interface writeback_unit_if #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
);
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rvalid;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              wb_done;
    logic              wb_err;
    modport master (input mem_rdata, mem_rvalid, output rf_we, rf_waddr, rf_wdata, wb_done, wb_err);
    modport slave (output mem_rdata, mem_rvalid, input rf_we, rf_waddr, rf_wdata, wb_done, wb_err);
endinterface

// File: rtl/writeback_unit_load_extender.sv
// writeback_unit_load_extender: little-endian lane select with sign/zero extension for loads
module writeback_unit_load_extender
    import writeback_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [1:0]        addr,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    input  logic [DATA_W-1:0] rdata,
    output logic [DATA_W-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = rdata[{addr, 3'b000} +: 8];
    assign h = rdata[{addr[1], 4'b0000} +: 16];
    assign data = load_size == LS_BYTE ? {{(DATA_W-8){~load_unsigned & b[7]}}, b}
                : load_size == LS_HALF ? {{(DATA_W-16){~load_unsigned & h[15]}}, h}
                : rdata;
endmodule

// File: rtl/writeback_unit.sv
// writeback_unit: captures EXEC results and load data, then issues one register-file write per instruction
module writeback_unit
    import writeback_unit_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int REG_AW      = 5,
    parameter int STATE_W     = 6,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [STATE_W-1:0] state,
    input  logic               reg_write_in,
    input  logic               mem_to_reg,
    input  logic               reg_dst,
    input  logic [REG_AW-1:0]  instr_rt,
    input  logic [REG_AW-1:0]  instr_rd,
    input  logic [1:0]         load_size,
    input  logic               load_unsigned,
    input  logic [DATA_W-1:0]  alu_result,
    writeback_unit_if.master   wb
);
    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);
    wb_state_t st, st_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [REG_AW-1:0] dest;
    logic [DATA_W-1:0] alu_q, ld_q, ld_ext;
    logic [1:0] ls_q;
    logic rw_q, m2r_q, lu_q, err_n, fetch;
    assign fetch = state == ST_FETCH;
    writeback_unit_load_extender #(.DATA_W(DATA_W)) u_ext (
        .addr(alu_q[1:0]),
        .load_size(ls_q),
        .load_unsigned(lu_q),
        .rdata(wb.mem_rdata),
        .data(ld_ext)
    );
    always_comb begin
        st_n = st;
        cnt_n = cnt;
        err_n = 1'b0;
        case (st)
            IDLE: st_n = state == ST_EXEC ? ARMED : IDLE;
            ARMED: begin
                if (fetch) st_n = IDLE;
                else if (state == ST_MEM) begin
                    st_n = !m2r_q ? READY : misaligned(ls_q, alu_q[1:0]) ? IDLE : WAIT_MEM;
                    err_n = m2r_q & misaligned(ls_q, alu_q[1:0]);
                    cnt_n = '0;
                end else if (state == ST_WB && !m2r_q) st_n = WRITE;
            end
            WAIT_MEM: begin
                st_n = fetch ? IDLE : wb.mem_rvalid ? READY : cnt == CNT_LAST ? IDLE : WAIT_MEM;
                err_n = !fetch && !wb.mem_rvalid && cnt == CNT_LAST;
                cnt_n = cnt + 1'b1;
            end
            READY: st_n = fetch ? IDLE : state == ST_WB ? WRITE : READY;
            WRITE: st_n = DONE;
            default: st_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st <= IDLE;
            cnt <= '0;
        end else begin
            st <= st_n;
            cnt <= cnt_n;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_q <= '0;
            ld_q <= '0;
            dest <= '0;
            ls_q <= '0;
            rw_q <= 1'b0;
            m2r_q <= 1'b0;
            lu_q <= 1'b0;
        end else begin
            if (st == IDLE && state == ST_EXEC) begin
                alu_q <= alu_result;
                rw_q <= reg_write_in;
                m2r_q <= mem_to_reg;
                ls_q <= load_size;
                lu_q <= load_unsigned;
                dest <= reg_dst ? instr_rd : instr_rt;
            end
            if (st == WAIT_MEM && st_n == READY) ld_q <= ld_ext;
        end
    end
    // outputs are registered off the next state so they line up with WRITE/DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb.rf_we <= 1'b0;
            wb.rf_waddr <= '0;
            wb.rf_wdata <= '0;
            wb.wb_done <= 1'b0;
            wb.wb_err <= 1'b0;
        end else begin
            wb.rf_we <= st_n == WRITE && rw_q && dest != REG_ZERO;
            wb.wb_done <= st_n == DONE;
            wb.wb_err <= err_n;
            if (st_n == WRITE) begin
                wb.rf_waddr <= dest;
                wb.rf_wdata <= m2r_q ? ld_q : alu_q;
            end
        end
    end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed-vector bench for writeback_unit with hand-computed expectations
module tb_writeback_unit;
    localparam logic [5:0] S_FETCH = 6'b000001;
    localparam logic [5:0] S_EXEC  = 6'b000100;
    localparam logic [5:0] S_MEM   = 6'b001000;
    localparam logic [5:0] S_WB    = 6'b010000;
    logic clk = 1'b0;
    logic rst_n;
    logic [5:0] state;
    logic reg_write_in, mem_to_reg, reg_dst, load_unsigned;
    logic [4:0] instr_rt, instr_rd;
    logic [1:0] load_size;
    logic [31:0] alu_result;
    int n_tests = 0;
    int n_fail = 0;
    writeback_unit_if #(.DATA_W(32), .REG_AW(5)) wb ();
    writeback_unit #(.DATA_W(32), .REG_AW(5), .STATE_W(6), .MEM_TIMEOUT(15)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .state(state),
        .reg_write_in(reg_write_in),
        .mem_to_reg(mem_to_reg),
        .reg_dst(reg_dst),
        .instr_rt(instr_rt),
        .instr_rd(instr_rd),
        .load_size(load_size),
        .load_unsigned(load_unsigned),
        .alu_result(alu_result),
        .wb(wb)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic cyc(input logic [5:0] s);
        state = s;
        @(posedge clk);
        #1;
    endtask
    task automatic setup(input logic rw, input logic m2r, input logic rsel, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [31:0] alu, input logic [1:0] ls, input logic u);
        reg_write_in = rw;
        mem_to_reg = m2r;
        reg_dst = rsel;
        instr_rt = rt;
        instr_rd = rd;
        alu_result = alu;
        load_size = ls;
        load_unsigned = u;
    endtask
    task automatic finish_wb(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        cyc(S_WB);
        check({tag, "_we"}, wb.rf_we, we);
        if (we) begin
            check({tag, "_waddr"}, wb.rf_waddr, a);
            check({tag, "_wdata"}, wb.rf_wdata, d);
        end
        check({tag, "_early_done"}, wb.wb_done, 0);
        cyc(S_FETCH);
        check({tag, "_done"}, wb.wb_done, 1);
        check({tag, "_we_off"}, wb.rf_we, 0);
        cyc(S_FETCH);
        check({tag, "_done_off"}, wb.wb_done, 0);
    endtask
    task automatic finish_none(input string tag);
        cyc(S_WB);
        check({tag, "_no_we"}, wb.rf_we, 0);
        cyc(S_FETCH);
        check({tag, "_no_done"}, wb.wb_done, 0);
        check({tag, "_no_err"}, wb.wb_err, 0);
    endtask
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [1:0] ls, input logic u,
                           input int dly, input logic [31:0] rdata, input logic [31:0] exp);
        setup(1'b1, 1'b1, 1'b0, 5'd8, 5'd3, addr, ls, u);
        wb.mem_rdata = rdata;
        cyc(S_EXEC);
        cyc(S_MEM);
        for (int i = 0; i < dly; i++) cyc(S_MEM);
        wb.mem_rvalid = 1'b1;
        cyc(S_MEM);
        wb.mem_rvalid = 1'b0;
        wb.mem_rdata = '0;
        check({tag, "_err"}, wb.wb_err, 0);
        finish_wb(tag, 1'b1, 5'd8, exp);
    endtask
    task automatic do_misal(input string tag, input logic [31:0] addr, input logic [1:0] ls);
        setup(1'b1, 1'b1, 1'b0, 5'd8, 5'd3, addr, ls, 1'b0);
        cyc(S_EXEC);
        cyc(S_MEM);
        check({tag, "_err"}, wb.wb_err, 1);
        check({tag, "_we"}, wb.rf_we, 0);
        cyc(S_MEM);
        check({tag, "_err_off"}, wb.wb_err, 0);
        finish_none(tag);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
    initial begin
        logic seen;
        rst_n = 1'b0;
        state = '0;
        setup(1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 32'h0, 2'b00, 1'b0);
        wb.mem_rdata = '0;
        wb.mem_rvalid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_we", wb.rf_we, 0);
        check("rst_waddr", wb.rf_waddr, 0);
        check("rst_wdata", wb.rf_wdata, 0);
        check("rst_done", wb.wb_done, 0);
        check("rst_err", wb.wb_err, 0);
        rst_n = 1'b1;
        setup(1'b1, 1'b0, 1'b1, 5'd9, 5'd5, 32'h0000_00A5, 2'b00, 1'b0);
        cyc(S_EXEC);
        cyc(S_MEM);
        finish_wb("rtype", 1'b1, 5'd5, 32'h0000_00A5);
        check("rtype_hold_waddr", wb.rf_waddr, 5);
        do_load("lb_s", 32'h1003, 2'b10, 1'b0, 2, 32'h8012_3456, 32'hFFFF_FF80);
        do_load("lbu", 32'h1003, 2'b10, 1'b1, 2, 32'h8012_3456, 32'h0000_0080);
        do_load("lb_lane1", 32'h1001, 2'b10, 1'b0, 0, 32'h8012_3456, 32'h0000_0034);
        do_load("lh_s", 32'h1002, 2'b01, 1'b0, 0, 32'h8012_3456, 32'hFFFF_8012);
        do_load("lhu_lo", 32'h1000, 2'b01, 1'b1, 1, 32'h8012_B456, 32'h0000_B456);
        do_load("lw_edge", 32'h1000, 2'b00, 1'b0, 14, 32'h8012_3456, 32'h8012_3456);
        do_misal("mis_half", 32'h1001, 2'b01);
        do_misal("mis_word", 32'h1002, 2'b00);
        setup(1'b1, 1'b1, 1'b0, 5'd8, 5'd3, 32'h1000, 2'b00, 1'b0);
        wb.mem_rdata = 32'hDEAD_BEEF;
        cyc(S_EXEC);
        cyc(S_MEM);
        seen = 1'b0;
        for (int i = 0; i < 14; i++) begin
            cyc(S_MEM);
            seen |= wb.wb_err;
        end
        check("to_early", seen, 0);
        cyc(S_MEM);
        check("to_err", wb.wb_err, 1);
        wb.mem_rvalid = 1'b1;
        cyc(S_MEM);
        wb.mem_rvalid = 1'b0;
        check("to_err_off", wb.wb_err, 0);
        finish_none("to_late");
        setup(1'b1, 1'b0, 1'b1, 5'd7, 5'd0, 32'h77, 2'b00, 1'b0);
        cyc(S_EXEC);
        cyc(S_MEM);
        finish_wb("zero", 1'b0, 5'd0, 32'h0);
        setup(1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 32'h99, 2'b00, 1'b0);
        cyc(S_EXEC);
        cyc(S_MEM);
        finish_wb("nowr", 1'b0, 5'd0, 32'h0);
        setup(1'b1, 1'b0, 1'b0, 5'd12, 5'd3, 32'h1234, 2'b00, 1'b0);
        cyc(S_EXEC);
        cyc(6'b000011);
        cyc(6'b000000);
        finish_wb("skip_mem", 1'b1, 5'd12, 32'h1234);
        setup(1'b1, 1'b1, 1'b0, 5'd8, 5'd3, 32'h1000, 2'b00, 1'b0);
        wb.mem_rdata = 32'h5555_AAAA;
        cyc(S_EXEC);
        cyc(S_MEM);
        #2 rst_n = 1'b0;
        #1;
        check("arst_waddr", wb.rf_waddr, 0);
        check("arst_wdata", wb.rf_wdata, 0);
        check("arst_we", wb.rf_we, 0);
        #1 rst_n = 1'b1;
        wb.mem_rvalid = 1'b1;
        cyc(S_MEM);
        wb.mem_rvalid = 1'b0;
        finish_none("arst");
        setup(1'b1, 1'b0, 1'b1, 5'd9, 5'd17, 32'h0000_CAFE, 2'b00, 1'b0);
        cyc(S_EXEC);
        cyc(S_MEM);
        finish_wb("post_rst", 1'b1, 5'd17, 32'h0000_CAFE);
        setup(1'b1, 1'b0, 1'b1, 5'd9, 5'd4, 32'h0000_BEEF, 2'b00, 1'b0);
        cyc(S_EXEC);
        cyc(S_MEM);
        cyc(S_FETCH);
        finish_none("abort_ready");
        check("abort_hold_wdata", wb.rf_wdata, 32'h0000_CAFE);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
